// File: rtl/mp_addsub.sv
// mp_addsub: multi-cycle wide adder/subtractor built from one narrow adder slice.
//
// Purpose
//   Computes A+B or A-B on OPERAND_WIDTH-bit operands by running a single
//   ADDER_WIDTH-bit adder for N = OPERAND_WIDTH/ADDER_WIDTH cycles, LSB slice
//   first, with the inter-slice carry held in a register.
//
// Ports
//   iClk    in   1      clock, rising edge
//   iRst    in   1      asynchronous active-high reset
//   iStart  in   1      start request, accepted only in IDLE
//   iSub    in   1      0 = add, 1 = subtract (A-B)
//   iOpA    in   OW     operand A
//   iOpB    in   OW     operand B
//   oRes    out  OW+1   result; MSB = carry (add) or borrow (sub)
//   oDone   out  1      one-cycle completion pulse
//   oBusy   out  1      high in RUN and DONE

module mp_addsub #(
    parameter int OPERAND_WIDTH = 128,
    parameter int ADDER_WIDTH   = 32
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iStart,
    input  logic                     iSub,
    input  logic [OPERAND_WIDTH-1:0] iOpA,
    input  logic [OPERAND_WIDTH-1:0] iOpB,
    output logic [OPERAND_WIDTH:0]   oRes,
    output logic                     oDone,
    output logic                     oBusy
);

    localparam int N     = OPERAND_WIDTH / ADDER_WIDTH;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if ((N < 1) || (OPERAND_WIDTH % ADDER_WIDTH != 0)) begin : g_bad_param
        $error("OPERAND_WIDTH must be a positive multiple of ADDER_WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [OPERAND_WIDTH-1:0] opa_q, opa_d;
    logic [OPERAND_WIDTH-1:0] opb_q, opb_d;
    logic                     sub_q, sub_d;
    logic                     carry_q, carry_d;
    logic [OPERAND_WIDTH-1:0] res_q, res_d;
    logic                     msb_q, msb_d;

    logic [ADDER_WIDTH-1:0]   a_sl;
    logic [ADDER_WIDTH-1:0]   b_sl;
    logic [ADDER_WIDTH:0]     sum_sl;
    logic [OPERAND_WIDTH-1:0] sum_ext;

    // The operand registers are shifted right one slice per RUN cycle, so
    // the current slice is always the low ADDER_WIDTH bits.
    always_comb begin
        a_sl   = opa_q[ADDER_WIDTH-1:0];
        b_sl   = sub_q ? ~opb_q[ADDER_WIDTH-1:0] : opb_q[ADDER_WIDTH-1:0];
        sum_sl = {1'b0, a_sl} + {1'b0, b_sl} + {{ADDER_WIDTH{1'b0}}, carry_q};
        // Each new slice enters at the top of the result register and the
        // earlier slices move down; after N cycles slice 0 sits at bit 0.
        sum_ext = OPERAND_WIDTH'(sum_sl[ADDER_WIDTH-1:0]) << (OPERAND_WIDTH - ADDER_WIDTH);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        res_d   = res_q;
        msb_d   = msb_q;

        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    opa_d   = iOpA;
                    opb_d   = iOpB;
                    sub_d   = iSub;
                    // Subtraction is A + ~B + 1: the +1 enters as carry-in.
                    carry_d = iSub;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                opa_d   = opa_q >> ADDER_WIDTH;
                opb_d   = opb_q >> ADDER_WIDTH;
                carry_d = sum_sl[ADDER_WIDTH];
                res_d   = (res_q >> ADDER_WIDTH) | sum_ext;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // Borrow is the inverse of the final carry.
                    msb_d   = sub_q ? ~sum_sl[ADDER_WIDTH] : sum_sl[ADDER_WIDTH];
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            res_q   <= '0;
            msb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            msb_q   <= msb_d;
        end
    end

    assign oRes  = {msb_q, res_q};
    assign oDone = (state_q == S_DONE);
    assign oBusy = (state_q != S_IDLE);

endmodule
